// File: rtl/risc_spm_pkg.sv
// Shared encodings for the RISC SPM control unit and datapath muxes:
// FSM states, opcodes, bus select codes and the decoded control word.
package risc_spm_pkg;

    typedef enum logic [3:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_RD   = 4'd5;
    localparam logic [3:0] OP_WR   = 4'd6;
    localparam logic [3:0] OP_BR   = 4'd7;
    localparam logic [3:0] OP_BRZ  = 4'd8;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [2:0] SEL1_R0 = 3'd0;
    localparam logic [2:0] SEL1_R1 = 3'd1;
    localparam logic [2:0] SEL1_R2 = 3'd2;
    localparam logic [2:0] SEL1_R3 = 3'd3;
    localparam logic [2:0] SEL1_PC = 3'd4;

    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;

    typedef struct packed {
        state_t     next;
        logic [3:0] load_r;
        logic       load_pc;
        logic       inc_pc;
        logic [2:0] sel1;
        logic [1:0] sel2;
        logic       load_ir;
        logic       load_add_r;
        logic       load_reg_y;
        logic       load_reg_z;
        logic       write;
    } ctrl_t;

endpackage

// File: rtl/risc_spm_control_unit.sv
// Multi-cycle control FSM for the RISC SPM: one state register plus a pure
// decode function producing next state and all strobes from state/IR/zero.
module risc_spm_control_unit
    import risc_spm_pkg::*;
#(
    parameter int word_size = 8,
    parameter int op_size   = 4,
    parameter int Sel1_size = 3,
    parameter int Sel2_size = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic                 Load_R0,
    output logic                 Load_R1,
    output logic                 Load_R2,
    output logic                 Load_R3,
    output logic                 Load_PC,
    output logic                 Inc_PC,
    output logic [Sel1_size-1:0] Sel_Bus_1_Mux,
    output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
    output logic                 Load_IR,
    output logic                 Load_Add_R,
    output logic                 Load_Reg_Y,
    output logic                 Load_Reg_Z,
    output logic                 write,
    output logic                 halted,
    output logic [3:0]           o_dbg_state
);

    state_t r_state;
    ctrl_t  w_ctrl;

    function automatic ctrl_t decode(input state_t st, input logic [3:0] op,
                                     input logic [1:0] src, input logic [1:0] dest,
                                     input logic z);
        ctrl_t c;
        c      = '0;
        c.next = st;
        case (st)
            S_idle: c.next = S_fet1;
            S_fet1: begin
                c.sel1 = SEL1_PC; c.sel2 = SEL2_BUS1; c.load_add_r = 1'b1;
                c.next = S_fet2;
            end
            S_fet2: begin
                c.sel2 = SEL2_MEM; c.load_ir = 1'b1; c.inc_pc = 1'b1;
                c.next = S_dec;
            end
            S_dec: begin
                case (op)
                    OP_NOP: c.next = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        c.sel1 = {1'b0, src}; c.sel2 = SEL2_BUS1; c.load_reg_y = 1'b1;
                        c.next = S_ex1;
                    end
                    OP_NOT: begin
                        c.sel1 = {1'b0, src}; c.sel2 = SEL2_ALU; c.load_reg_z = 1'b1;
                        c.load_r[dest] = 1'b1;
                        c.next = S_fet1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        c.sel1 = SEL1_PC; c.sel2 = SEL2_BUS1; c.load_add_r = 1'b1;
                        c.next = (op == OP_RD) ? S_rd1 : (op == OP_WR) ? S_wr1 : S_br1;
                    end
                    OP_BRZ: begin
                        if (z) begin
                            c.sel1 = SEL1_PC; c.sel2 = SEL2_BUS1; c.load_add_r = 1'b1;
                            c.next = S_br1;
                        end else begin
                            // Not taken: step PC over the branch target word.
                            c.inc_pc = 1'b1;
                            c.next   = S_fet1;
                        end
                    end
                    default: c.next = S_halt;
                endcase
            end
            S_ex1: begin
                c.sel1 = {1'b0, dest}; c.sel2 = SEL2_ALU; c.load_reg_z = 1'b1;
                c.load_r[dest] = 1'b1;
                c.next = S_fet1;
            end
            S_rd1, S_wr1: begin
                c.sel2 = SEL2_MEM; c.load_add_r = 1'b1; c.inc_pc = 1'b1;
                c.next = (st == S_rd1) ? S_rd2 : S_wr2;
            end
            S_rd2: begin
                c.sel2 = SEL2_MEM; c.load_r[dest] = 1'b1;
                c.next = S_fet1;
            end
            S_wr2: begin
                c.sel1 = {1'b0, src}; c.write = 1'b1;
                c.next = S_fet1;
            end
            S_br1: begin
                c.sel2 = SEL2_MEM; c.load_add_r = 1'b1;
                c.next = S_br2;
            end
            S_br2: begin
                c.sel2 = SEL2_MEM; c.load_pc = 1'b1;
                c.next = S_fet1;
            end
            S_halt:  c.next = S_halt;
            default: c.next = S_idle;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_idle;
        end else begin
            r_state <= w_ctrl.next;
        end
    end

    always_comb begin
        w_ctrl = decode(r_state, instruction[word_size-1 -: op_size],
                        instruction[3:2], instruction[1:0], zero);
    end

    assign Load_R0       = w_ctrl.load_r[0];
    assign Load_R1       = w_ctrl.load_r[1];
    assign Load_R2       = w_ctrl.load_r[2];
    assign Load_R3       = w_ctrl.load_r[3];
    assign Load_PC       = w_ctrl.load_pc;
    assign Inc_PC        = w_ctrl.inc_pc;
    assign Sel_Bus_1_Mux = Sel1_size'(w_ctrl.sel1);
    assign Sel_Bus_2_Mux = Sel2_size'(w_ctrl.sel2);
    assign Load_IR       = w_ctrl.load_ir;
    assign Load_Add_R    = w_ctrl.load_add_r;
    assign Load_Reg_Y    = w_ctrl.load_reg_y;
    assign Load_Reg_Z    = w_ctrl.load_reg_z;
    assign write         = w_ctrl.write;
    assign halted        = (r_state == S_halt);
    assign o_dbg_state   = r_state;

endmodule

// File: doc/risc_spm_control_unit.md
RISC_SPM_CONTROL_UNIT -- requirements
Module: risc_spm_control_unit

Interface
REQ-001 Parameters SHALL be: word_size, default 8, instruction width; op_size, default 4, opcode width; Sel1_size, default 3, Bus_1 mux select width; Sel2_size, default 2, Bus_2 mux select width.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 instruction  input  word_size  current IR contents: opcode [7:4], src [3:2], dest [1:0].
REQ-005 zero  input  1  ALU zero flag from Reg_Z path.
REQ-006 Load_R0, Load_R1, Load_R2, Load_R3  output  1 each  register file load strobes.
REQ-007 Load_PC, Inc_PC  output  1 each  program counter load and increment strobes.
REQ-008 Sel_Bus_1_Mux  output  Sel1_size  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
REQ-009 Sel_Bus_2_Mux  output  Sel2_size  Bus_2 source: 0=ALU, 1=Bus_1, 2=memory.
REQ-010 Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, write  output  1 each  IR, address register, ALU operand, ALU result and memory write strobes.
REQ-011 halted  output  1  high only in state S_halt.

Function
REQ-012 State register SHALL hold: S_idle, S_fet1, S_fet2, S_dec, S_ex1, S_rd1, S_rd2, S_wr1, S_wr2, S_br1, S_br2, S_halt.
REQ-013 Outputs SHALL be combinational decode of current state, instruction and zero; every unlisted output is 0, and both select fields are 0.
REQ-014 Opcodes SHALL be: NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8, HALT=15; any other opcode is treated as HALT.
REQ-015 S_idle: no strobes; next state S_fet1.
REQ-016 S_fet1: Sel_Bus_1=PC, Sel_Bus_2=Bus_1, Load_Add_R; next S_fet2.
REQ-017 S_fet2: Sel_Bus_2=memory, Load_IR, Inc_PC; next S_dec.
REQ-018 S_dec, NOP: no strobes; next S_fet1.
REQ-019 S_dec, ADD/SUB/AND: Sel_Bus_1=src, Sel_Bus_2=Bus_1, Load_Reg_Y; next S_ex1.
REQ-020 S_dec, NOT: Sel_Bus_1=src, Sel_Bus_2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-021 S_dec, RD/WR/BR: Sel_Bus_1=PC, Sel_Bus_2=Bus_1, Load_Add_R; next S_rd1/S_wr1/S_br1 respectively.
REQ-022 S_dec, BRZ with zero=1: behaves as BR. With zero=0: Inc_PC only (skip operand word); next S_fet1. zero is sampled only in S_dec.
REQ-023 S_ex1: Sel_Bus_1=dest, Sel_Bus_2=ALU, Load_Reg_Z, Load_R[dest]; next S_fet1.
REQ-024 S_rd1 and S_wr1: Sel_Bus_2=memory, Load_Add_R, Inc_PC; next S_rd2/S_wr2.
REQ-025 S_rd2: Sel_Bus_2=memory, Load_R[dest]; next S_fet1.
REQ-026 S_wr2: Sel_Bus_1=src, write; next S_fet1.
REQ-027 S_br1: Sel_Bus_2=memory, Load_Add_R; next S_br2. S_br2: Sel_Bus_2=memory, Load_PC; next S_fet1.
REQ-028 S_dec, HALT/illegal: no strobes; next S_halt. S_halt SHALL be absorbing until reset.
REQ-029 Invariants: Load_PC and Inc_PC are never high together; at most one Load_Rx is high in any cycle; write is high only in S_wr2.
REQ-030 Latencies from S_fet1 entry: NOT/NOP 3 cycles, ALU ops 4 cycles, RD/WR/BR/BRZ-taken 5 cycles, BRZ-not-taken 3 cycles.

Reset
REQ-031 rst low SHALL force S_idle immediately, independent of clk; all outputs 0 and halted=0 while rst is low.
REQ-032 Reset asserted mid-instruction SHALL abandon the instruction; the first edge after release enters S_fet1.

Structure
REQ-033 State encoding (4-bit), opcode constants and Bus_1/Bus_2 select constants SHALL live in shared package risc_spm_pkg, shared with the datapath muxes.
REQ-034 Split: next-state/output decode function inside the module plus one state register; no sub-module required.

Verification
REQ-035 Reset, then instruction=0x00 (NOP) -> states idle, fet1, fet2, dec, fet1; Inc_PC exactly once.
REQ-036 instruction=0x1B (ADD R2,R3) -> dec: Sel_Bus_1=2, Load_Reg_Y; ex1: Sel_Bus_1=3, Sel_Bus_2=0, Load_Reg_Z, Load_R3.
REQ-037 instruction=0x52 (RD R2) -> rd1: Inc_PC, Load_Add_R; rd2: Sel_Bus_2=2, Load_R2; back to fet1.
REQ-038 instruction=0x80 (BRZ) with zero=0 -> dec: Inc_PC, next fet1; with zero=1 -> br1, br2 with Load_PC, Inc_PC never high in br2.
REQ-039 instruction=0xA0 (illegal) -> S_halt, halted=1 held 20 cycles; rst low during S_wr2 -> outputs 0 asynchronously, write drops at once.
